// File: rtl/bch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bch_ctrl_pkg
// Shared definitions for the BCH command scheduler: FSM state encoding,
// accepted opcodes, response header codes and small decode helpers.
// -----------------------------------------------------------------------------
package bch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DISPATCH  = 3'd1,
    WAIT_ENG  = 3'd2,
    SEND_HDR  = 3'd3,
    SEND_DATA = 3'd4
  } state_t;

  localparam logic [7:0] OP_ENCODE   = 8'h01;
  localparam logic [7:0] OP_DECODE   = 8'h02;

  localparam logic [7:0] HDR_OK      = 8'hA0;
  localparam logic [7:0] HDR_ERR     = 8'hE0;
  localparam logic [7:0] HDR_TIMEOUT = 8'hEF;

  // Only encode and decode are dispatched to the engine.
  function automatic logic is_valid_op(input logic [7:0] op);
    return (op == OP_ENCODE) || (op == OP_DECODE);
  endfunction

  // Status header: class code in the upper nibble, opcode echoed below.
  function automatic logic [7:0] resp_header(input logic err, input logic [7:0] op);
    return (err ? HDR_ERR : HDR_OK) | op;
  endfunction

endpackage

// File: rtl/resp_serializer.sv
// -----------------------------------------------------------------------------
// resp_serializer
// Loads a response header plus a multi-byte result and streams them out over a
// valid/ready byte handshake, header first, then result bytes MSB first.
//
// Ports:
//   clk_i       in   system clock
//   rst_i       in   synchronous active-high reset
//   load_i      in   capture hdr_i/data_i and start presenting the header
//   hdr_i       in   DATA_W-bit header byte
//   data_i      in   DATA_W*RESP_BYTES result word
//   tx_byte_o   out  byte currently presented (held while not accepted)
//   tx_valid_o  out  tx_byte_o is valid
//   tx_ready_i  in   receiver accepts the byte this cycle
//   xfer_o      out  a byte transfers on the coming edge
//   last_o      out  the final byte of the response transfers on the coming edge
// -----------------------------------------------------------------------------
module resp_serializer #(
  parameter int DATA_W     = 8,
  parameter int RESP_BYTES = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         load_i,
  input  logic [DATA_W-1:0]            hdr_i,
  input  logic [DATA_W*RESP_BYTES-1:0] data_i,
  output logic [DATA_W-1:0]            tx_byte_o,
  output logic                         tx_valid_o,
  input  logic                         tx_ready_i,
  output logic                         xfer_o,
  output logic                         last_o
);

  localparam int RES_W = DATA_W * RESP_BYTES;
  localparam int CNT_W = $clog2(RESP_BYTES + 1);

  logic [RES_W-1:0] shift_q;
  logic [CNT_W-1:0] rem_q;   // bytes still queued behind the one on tx_byte_o

  assign xfer_o = tx_valid_o & tx_ready_i;
  assign last_o = xfer_o & (rem_q == CNT_W'(0));

  // Load / handshake / shift-out register set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q    <= '0;
      rem_q      <= '0;
      tx_byte_o  <= '0;
      tx_valid_o <= 1'b0;
    end else if (load_i) begin
      shift_q    <= data_i;
      rem_q      <= CNT_W'(RESP_BYTES);
      tx_byte_o  <= hdr_i;
      tx_valid_o <= 1'b1;
    end else if (xfer_o) begin
      if (rem_q == CNT_W'(0)) begin
        tx_valid_o <= 1'b0;
        tx_byte_o  <= '0;
      end else begin
        tx_byte_o <= shift_q[RES_W-1 -: DATA_W];
        shift_q   <= shift_q << DATA_W;
        rem_q     <= rem_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bch_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// bch_cmd_scheduler
// Accepts a command frame from the UART receive path (rising edge of
// cmd_valid_i), dispatches encode/decode to the BCH engine with a start/done
// handshake, then returns a status header plus the result bytes to the UART
// transmitter. One command in flight; frames arriving while busy, or carrying
// an unknown opcode, are dropped with a one-cycle drop_o pulse.
//
// Optional feature: define BCH_TIMEOUT_EN to build an engine watchdog that
// gives up after TIMEOUT_CYCLES cycles in WAIT_ENG and answers 8'hEF + zeros.
//
// Ports:
//   clk_i          in   system clock
//   rst_i          in   synchronous active-high reset
//   cmd_i          in   frame: opcode in the top byte, payload below
//   cmd_valid_i    in   frame-ready level (rising edge = frame event)
//   eng_op_o       out  2'b01 encode, 2'b10 decode
//   eng_payload_o  out  latched payload
//   eng_start_o    out  one-cycle start pulse
//   eng_done_i     in   engine completion (sampled in WAIT_ENG only)
//   eng_err_i      in   engine error, valid with eng_done_i
//   eng_result_i   in   engine result, valid with eng_done_i
//   tx_byte_o      out  response byte
//   tx_valid_o     out  response byte valid
//   tx_ready_i     in   transmitter accepts byte
//   busy_o         out  command in flight
//   drop_o         out  one-cycle pulse on a rejected frame
// -----------------------------------------------------------------------------
module bch_cmd_scheduler
  import bch_ctrl_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int PARAMETERS     = 6,
  parameter int RESP_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [DATA_W*PARAMETERS-1:0]        cmd_i,
  input  logic                                cmd_valid_i,
  output logic [1:0]                          eng_op_o,
  output logic [DATA_W*(PARAMETERS-1)-1:0]    eng_payload_o,
  output logic                                eng_start_o,
  input  logic                                eng_done_i,
  input  logic                                eng_err_i,
  input  logic [DATA_W*RESP_BYTES-1:0]        eng_result_i,
  output logic [DATA_W-1:0]                   tx_byte_o,
  output logic                                tx_valid_o,
  input  logic                                tx_ready_i,
  output logic                                busy_o,
  output logic                                drop_o
);

  localparam int FRAME_W = DATA_W * PARAMETERS;
  localparam int PAY_W   = FRAME_W - DATA_W;
  localparam int RES_W   = DATA_W * RESP_BYTES;

  state_t              state_q;
  logic                cmd_valid_q;
  logic [DATA_W-1:0]   op_q;

  logic                frame_evt;
  logic [DATA_W-1:0]   frame_op;
  logic                to_hit;

  logic                ser_load;
  logic [DATA_W-1:0]   ser_hdr;
  logic [RES_W-1:0]    ser_data;
  logic                ser_xfer;
  logic                ser_last;

  assign frame_evt = cmd_valid_i & ~cmd_valid_q;
  assign frame_op  = cmd_i[FRAME_W-1 -: DATA_W];

`ifdef BCH_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt_q;

  // Watchdog: cleared while in DISPATCH so it starts at 0 on WAIT_ENG entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
    end else if (state_q == DISPATCH) begin
      to_cnt_q <= '0;
    end else if (state_q == WAIT_ENG) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  assign to_hit = (state_q == WAIT_ENG) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  // Serializer load: engine done takes priority over a coincident timeout.
  always_comb begin
    ser_load = 1'b0;
    ser_hdr  = '0;
    ser_data = '0;
    if ((state_q == WAIT_ENG) && eng_done_i) begin
      ser_load = 1'b1;
      ser_hdr  = resp_header(eng_err_i, op_q);
      ser_data = eng_result_i;
    end else if (to_hit) begin
      ser_load = 1'b1;
      ser_hdr  = HDR_TIMEOUT;
      ser_data = '0;
    end else begin
      ser_load = 1'b0;
    end
  end

  // Command FSM with registered engine/status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cmd_valid_q   <= 1'b0;
      op_q          <= '0;
      eng_op_o      <= 2'b00;
      eng_payload_o <= '0;
      eng_start_o   <= 1'b0;
      busy_o        <= 1'b0;
      drop_o        <= 1'b0;
    end else begin
      cmd_valid_q <= cmd_valid_i;
      eng_start_o <= 1'b0;
      // Any frame event outside IDLE is rejected; IDLE overrides below.
      drop_o      <= frame_evt & (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (frame_evt) begin
            if (is_valid_op(frame_op)) begin
              op_q          <= frame_op;
              eng_op_o      <= frame_op[1:0];
              eng_payload_o <= cmd_i[PAY_W-1:0];
              eng_start_o   <= 1'b1;
              busy_o        <= 1'b1;
              state_q       <= DISPATCH;
            end else begin
              drop_o <= 1'b1;
            end
          end
        end
        DISPATCH: begin
          state_q <= WAIT_ENG;
        end
        WAIT_ENG: begin
          if (ser_load) begin
            state_q <= SEND_HDR;
          end
        end
        SEND_HDR: begin
          if (ser_last) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
          end else if (ser_xfer) begin
            state_q <= SEND_DATA;
          end
        end
        SEND_DATA: begin
          if (ser_last) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

  resp_serializer #(
    .DATA_W     (DATA_W),
    .RESP_BYTES (RESP_BYTES)
  ) u_resp_serializer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (ser_load),
    .hdr_i      (ser_hdr),
    .data_i     (ser_data),
    .tx_byte_o  (tx_byte_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .xfer_o     (ser_xfer),
    .last_o     (ser_last)
  );

endmodule
